// File: rtl/edge_event_arbiter.sv
// Purpose : per-channel edge detector feeding a round-robin arbiter that presents one event at a time.
// Latency : a detection on edge N is presented after edge N+1 (plus 2 edges with EDGE_ARB_SYNC_EN).
// Backpres: evt_valid_o/evt_ch_o hold while evt_ready_i=0; further edges on a pending channel set its ovf flag.
//
// Ports:
//   clk, rst_ni      - clock, asynchronous active-low reset
//   sig_i            - monitored levels, one bit per channel
//   mode_i           - per-channel mode in bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
//   evt_valid_o      - registered event-present flag
//   evt_ch_o         - channel index of the presented event
//   evt_ready_i      - consumer accepts the presented event
//   pending_o        - latched events not yet presented
//   ovf_o            - sticky overflow flags
//   ovf_clr_i        - overflow clear strobes
// Configuration macro: EDGE_ARB_SYNC_EN adds a 2-flop input synchronizer (warm-up grows from 1 to 3 cycles).
module edge_event_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst_ni,
   input  logic [NUM_CH-1:0]   sig_i,
   input  logic [2*NUM_CH-1:0] mode_i,
   output logic                evt_valid_o,
   output logic [CH_W-1:0]     evt_ch_o,
   input  logic                evt_ready_i,
   output logic [NUM_CH-1:0]   pending_o,
   output logic [NUM_CH-1:0]   ovf_o,
   input  logic [NUM_CH-1:0]   ovf_clr_i
);

   logic [NUM_CH-1:0] s;
   logic [NUM_CH-1:0] prev;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;
   logic [NUM_CH-1:0] det;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] ovf;
   logic [NUM_CH-1:0] load_mask;
   logic [CH_W-1:0]   last_grant;
   logic [CH_W-1:0]   sel;
   logic              any_pend;
   logic              load_en;
   logic              load;
   logic [1:0]        warm_cnt;
   logic              warm_active;

`ifdef EDGE_ARB_SYNC_EN
   // Three edges are needed before prev reflects a level held across reset:
   // two to fill the synchronizer and one more to copy it into prev.
   localparam logic [1:0] WARM_CYCLES = 2'd3;

   logic [NUM_CH-1:0] sync1;
   logic [NUM_CH-1:0] sync2;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sig_i;
         sync2 <= sync1;
      end
   end

   assign s = sync2;
`else
   // prev starts at 0, so one suppressed edge hides a level held high across reset.
   localparam logic [1:0] WARM_CYCLES = 2'd1;

   assign s = sig_i;
`endif

   // Warm-up counter: detection is masked while non-zero.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         warm_cnt <= WARM_CYCLES;
      end else if (warm_cnt != 2'd0) begin
         warm_cnt <= warm_cnt - 2'd1;
      end
   end

   assign warm_active = (warm_cnt != 2'd0);

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         prev <= '0;
      end else begin
         prev <= s;
      end
   end

   assign rise = s & ~prev;
   assign fall = ~s & prev;

   always_comb begin
      det = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         case (mode_i[2*c +: 2])
            2'b01:   det[c] = rise[c];
            2'b10:   det[c] = fall[c];
            2'b11:   det[c] = rise[c] | fall[c];
            default: det[c] = 1'b0;
         endcase
      end
      if (warm_active) begin
         det = '0;
      end
   end

   // Round-robin pick: first pending channel after last_grant, wrapping.
   always_comb begin
      logic [CH_W-1:0] idx;
      logic            found;
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = CH_W'((int'(last_grant) + i) % NUM_CH);
         if (!found && pending[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign any_pend = |pending;
   // The output register may take a new event when empty or being emptied this cycle.
   assign load_en  = !evt_valid_o || evt_ready_i;
   assign load     = load_en && any_pend;

   always_comb begin
      load_mask = '0;
      if (load) begin
         load_mask[sel] = 1'b1;
      end
   end

   // A new detection on the channel being loaded re-arms pending instead of overflowing;
   // only a detection on a still-waiting channel counts as overflow.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         pending <= '0;
         ovf     <= '0;
      end else begin
         pending <= (pending & ~load_mask) | det;
         ovf     <= (ovf & ~ovf_clr_i) | (det & pending & ~load_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         evt_valid_o <= 1'b0;
         evt_ch_o    <= '0;
         last_grant  <= CH_W'(NUM_CH - 1);
      end else if (load_en) begin
         evt_valid_o <= any_pend;
         if (any_pend) begin
            evt_ch_o   <= sel;
            last_grant <= sel;
         end
      end
   end

   assign pending_o = pending;
   assign ovf_o     = ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Purpose : directed self-checking bench for edge_event_arbiter (NUM_CH=4).
// Latency : observes outputs 1 time unit after each rising edge; inputs change at the same point.
// Backpres: drives evt_ready_i low/high per scenario to exercise hold, overflow and reload.
module tb_edge_event_arbiter;

`ifdef EDGE_ARB_SYNC_EN
   localparam int EX   = 2;
   localparam int WARM = 3;
`else
   localparam int EX   = 0;
   localparam int WARM = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_ni;
   logic [3:0] sig_i;
   logic [7:0] mode_i;
   logic       evt_valid_o;
   logic [1:0] evt_ch_o;
   logic       evt_ready_i;
   logic [3:0] pending_o;
   logic [3:0] ovf_o;
   logic [3:0] ovf_clr_i;

   // Observation word: {valid, ch[1:0], pending[3:0], ovf[3:0]}
   logic [10:0] obs;
   logic [10:0] exp_o;
   int checks   = 0;
   int failures = 0;

   assign obs = {evt_valid_o, evt_ch_o, pending_o, ovf_o};

   edge_event_arbiter #(.NUM_CH(4)) dut (
      .clk         (clk),
      .rst_ni      (rst_ni),
      .sig_i       (sig_i),
      .mode_i      (mode_i),
      .evt_valid_o (evt_valid_o),
      .evt_ch_o    (evt_ch_o),
      .evt_ready_i (evt_ready_i),
      .pending_o   (pending_o),
      .ovf_o       (ovf_o),
      .ovf_clr_i   (ovf_clr_i)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [3:0] sig_v, input logic [7:0] mode_v, input logic rdy);
      rst_ni      = 1'b0;
      sig_i       = sig_v;
      mode_i      = mode_v;
      evt_ready_i = rdy;
      ovf_clr_i   = 4'b0000;
      step(2);
      rst_ni = 1'b1;
      step(WARM);
   endtask

   task automatic test_reset;
      rst_ni = 1'b0; sig_i = 4'b0000; mode_i = 8'hFF; evt_ready_i = 1'b1; ovf_clr_i = 4'b0000;
      step(3);
      exp_o = {1'b0, 2'd0, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL reset_state got=%b exp=%b", obs, exp_o); end
      rst_ni = 1'b1;
      step(WARM + 2);
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, exp_o); end
   endtask

   task automatic test_single;
      do_reset(4'b0000, 8'b01010101, 1'b1);
      sig_i = 4'b0100;
      step(1 + EX);
      exp_o = {1'b0, 2'd0, 4'b0100, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL single_pending got=%b exp=%b", obs, exp_o); end
      step(1);
      exp_o = {1'b1, 2'd2, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL single_present got=%b exp=%b", obs, exp_o); end
      step(1);
      exp_o = {1'b0, 2'd2, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL single_pulse_end got=%b exp=%b", obs, exp_o); end
   endtask

   task automatic test_burst;
      logic [3:0] pend_tab [4];
      pend_tab = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
      do_reset(4'b0000, 8'b01010101, 1'b1);
      sig_i = 4'b1111;
      step(1 + EX);
      exp_o = {1'b0, 2'd0, 4'b1111, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL burst_pending got=%b exp=%b", obs, exp_o); end
      for (int k = 0; k < 4; k++) begin
         step(1);
         exp_o = {1'b1, 2'(k), pend_tab[k], 4'b0000};
         checks++; if (obs !== exp_o) begin failures++; $display("FAIL burst_ch%0d got=%b exp=%b", k, obs, exp_o); end
      end
      step(1);
      exp_o = {1'b0, 2'd3, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL burst_idle got=%b exp=%b", obs, exp_o); end
   endtask

   task automatic test_overflow;
      // ch1 falling-edge mode, consumer stalled
      do_reset(4'b0010, 8'b00001000, 1'b0);
      sig_i = 4'b0000; step(1 + EX);
      exp_o = {1'b0, 2'd0, 4'b0010, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_first_pending got=%b exp=%b", obs, exp_o); end
      step(1);
      exp_o = {1'b1, 2'd1, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_first_present got=%b exp=%b", obs, exp_o); end
      sig_i = 4'b0010; step(1 + EX);
      sig_i = 4'b0000; step(1 + EX);
      exp_o = {1'b1, 2'd1, 4'b0010, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_second_fall got=%b exp=%b", obs, exp_o); end
      sig_i = 4'b0010; step(1 + EX);
      sig_i = 4'b0000; step(1 + EX);
      exp_o = {1'b1, 2'd1, 4'b0010, 4'b0010};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_set got=%b exp=%b", obs, exp_o); end
      ovf_clr_i = 4'b0010; step(1); ovf_clr_i = 4'b0000;
      exp_o = {1'b1, 2'd1, 4'b0010, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_clear got=%b exp=%b", obs, exp_o); end
      // set and clear on the same edge: set wins
      sig_i = 4'b0010; step(1 + EX);
      sig_i = 4'b0000; step(EX);
      ovf_clr_i = 4'b0010; step(1); ovf_clr_i = 4'b0000;
      exp_o = {1'b1, 2'd1, 4'b0010, 4'b0010};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_set_beats_clr got=%b exp=%b", obs, exp_o); end
      ovf_clr_i = 4'b0010; step(1); ovf_clr_i = 4'b0000;
      // mode off: edges ignored, pending kept
      mode_i = 8'b00000000;
      sig_i = 4'b0010; step(1 + EX);
      sig_i = 4'b0000; step(1 + EX);
      exp_o = {1'b1, 2'd1, 4'b0010, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL mode_off_keeps got=%b exp=%b", obs, exp_o); end
      evt_ready_i = 1'b1; step(1);
      exp_o = {1'b1, 2'd1, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_drain got=%b exp=%b", obs, exp_o); end
      step(1);
      exp_o = {1'b0, 2'd1, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL ovf_idle got=%b exp=%b", obs, exp_o); end
   endtask

   task automatic test_back_to_back;
      do_reset(4'b0000, 8'b01010101, 1'b0);
      sig_i = 4'b0001; step(1 + EX); step(1);
      exp_o = {1'b1, 2'd0, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL b2b_first got=%b exp=%b", obs, exp_o); end
      sig_i = 4'b0000; step(1 + EX);
      sig_i = 4'b0001; step(1 + EX);
      exp_o = {1'b1, 2'd0, 4'b0001, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL b2b_waiting got=%b exp=%b", obs, exp_o); end
      // third rise lands on the edge where ch0 is accepted and reloaded
      sig_i = 4'b0000; step(1 + EX);
      sig_i = 4'b0001; step(EX);
      evt_ready_i = 1'b1; step(1);
      exp_o = {1'b1, 2'd0, 4'b0001, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL b2b_reload_rearm got=%b exp=%b", obs, exp_o); end
      step(1);
      exp_o = {1'b1, 2'd0, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL b2b_second got=%b exp=%b", obs, exp_o); end
      step(1);
      exp_o = {1'b0, 2'd0, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL b2b_idle got=%b exp=%b", obs, exp_o); end
   endtask

   task automatic test_round_robin;
      do_reset(4'b0000, 8'b01010101, 1'b0);
      sig_i = 4'b0100; step(1 + EX); step(1);
      sig_i = 4'b1101; step(1 + EX);
      exp_o = {1'b1, 2'd2, 4'b1001, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL rr_hold got=%b exp=%b", obs, exp_o); end
      evt_ready_i = 1'b1; step(1);
      exp_o = {1'b1, 2'd3, 4'b0001, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL rr_after_grant2 got=%b exp=%b", obs, exp_o); end
      step(1);
      exp_o = {1'b1, 2'd0, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL rr_wrap got=%b exp=%b", obs, exp_o); end
   endtask

   task automatic test_warmup_reset;
      do_reset(4'b1111, 8'hFF, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1);
         exp_o = {1'b0, 2'd0, 4'b0000, 4'b0000};
         checks++; if (obs !== exp_o) begin failures++; $display("FAIL warmup_quiet%0d got=%b exp=%b", k, obs, exp_o); end
      end
      sig_i = 4'b1110; step(1 + EX); step(1);
      exp_o = {1'b1, 2'd0, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL warmup_event got=%b exp=%b", obs, exp_o); end
      rst_ni = 1'b0; #1;
      exp_o = {1'b0, 2'd0, 4'b0000, 4'b0000};
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL reset_midhandshake got=%b exp=%b", obs, exp_o); end
      step(1);
      rst_ni = 1'b1;
      evt_ready_i = 1'b1;
      step(WARM + 5);
      checks++; if (obs !== exp_o) begin failures++; $display("FAIL no_represent got=%b exp=%b", obs, exp_o); end
   endtask

   initial begin
      rst_ni = 1'b0; sig_i = '0; mode_i = '0; evt_ready_i = 1'b0; ovf_clr_i = '0;
      test_reset;
      test_single;
      test_burst;
      test_overflow;
      test_back_to_back;
      test_round_robin;
      test_warmup_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
